uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Parametrised UART receiver with a receive FIFO, for on-chip use and as the reusable serial monitor in system benches.
- Samples a serial line on the core clock and reconstructs characters of configurable width, parity and stop-bit count.
- Flags framing, parity and overrun errors.
- Buffers good characters in a first-word-fall-through FIFO drained by a simple read strobe.

Parameters:
- CLK_PER_BIT, 8, core clocks per bit period; must be >= 4.
- DATA_BITS, 8, character width, 5..9.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits checked, 1 or 2.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.
- SYNC_STAGES, 2, rx input synchroniser flops, >= 2.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx  in  1  asynchronous serial input; idle high.
- rd_en  in  1  pop head of FIFO; ignored when empty.
- rd_data  out  DATA_BITS  FIFO head; valid while empty = 0.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- busy  out  1  receiver not in IDLE.
- frame_err  out  1  one-cycle pulse: a stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overrun  out  1  one-cycle pulse: good character dropped because FIFO full.

Behaviour:
- Single clock domain (clk); reset is asynchronous, active-low (rst_n).
- Reset values:
  - Synchroniser flops 1; FSM IDLE; FIFO pointers 0.
  - empty = 1, full = 0, count = 0, busy = 0, all error pulses 0, rd_data = 0.
- Reset mid-frame: the partial character is discarded. After release, the receiver waits for a falling edge and never resumes the old frame.
- Synchronised line value is rxs; all decisions use rxs. Input-to-rxs latency is SYNC_STAGES cycles.
- Bit timer: cnt counts down from its load value to 0; a sample is taken when cnt == 0.
- FSM:
  - IDLE: rxs high-to-low edge -> START, cnt = CLK_PER_BIT/2 - 1.
  - START: at sample, rxs = 1 is a false start -> IDLE with no flag; rxs = 0 -> DATA, cnt = CLK_PER_BIT - 1, bit index 0.
  - DATA: sample each bit LSB-first into a shift register. After bit DATA_BITS-1, go to PARITY if PARITY != 0, else STOP. Reload cnt = CLK_PER_BIT - 1 after every sample.
  - PARITY: sample and compare against the XOR of the data bits (even) or its inverse (odd); latch the mismatch, then -> STOP.
  - STOP: sample STOP_BITS times. Any low stop bit -> pulse frame_err, drop the character, go to BREAK. Otherwise, at the last stop sample: parity mismatch -> pulse parity_err and drop; else push the character, then -> IDLE.
  - BREAK: wait for rxs = 1, then -> IDLE. Prevents a held-low line from retriggering.
- busy = (state != IDLE).
- Push occurs on the cycle after the final stop sample; empty falls on the following cycle.
- frame_err takes precedence over parity_err; only one error pulse per character.
- FIFO:
  - First-word-fall-through; rd_data always shows the oldest entry.
  - Pop on rd_en & !empty.
  - Push when full with no simultaneous pop -> pulse overrun, drop the new character, keep FIFO contents.
  - Push and pop in the same cycle are both accepted, including when full; count unchanged.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits with natural wrap. full/empty derive from pointer MSB and equality.

Decomposition:
- Package uart_pkg:
  - parity encodings PAR_NONE / PAR_EVEN / PAR_ODD.
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Localparam helper for count width.
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports clk, rst_n, push, push_data, pop, rd_data, empty, full, count.
- Synchroniser, bit timer and FSM stay in uart_rx_fifo.

Test Plan:
1. CLK_PER_BIT = 8, 8N1, send 0x55 then 0xA3, no reads -> count = 2, rd_data = 0x55; one rd_en -> rd_data = 0xA3; second rd_en -> empty = 1. No error pulses.
2. Low glitch of 3 clocks (< CLK_PER_BIT/2) on an idle line -> busy pulses briefly, returns to IDLE; no push, no errors.
3. PARITY = 1, send 0x07 with the parity bit set to 0 (correct is 1) -> single parity_err pulse, FIFO stays empty. Then 0x07 with parity 1 -> rd_data = 0x07.
4. Send 0x3C with the stop bit driven low, line then held low 40 clocks, then high -> exactly one frame_err, state held in BREAK until high, no push. Next frame 0x11 received correctly.
5. FIFO_DEPTH = 4, send 0x01..0x05 with no reads -> full = 1 after the 4th; overrun pulse on the 5th; reads return 0x01..0x04 in order. Then fill to full and assert rd_en on the push cycle -> count stays 4, no overrun.
6. Assert rst_n = 0 mid-DATA of 0x9E, release, send 0x42 -> only 0x42 in FIFO; all outputs at reset values while rst_n is low.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice.
//   PAR_*        : parity mode encodings for the PARITY parameter
//   rx_state_t   : receiver FSM states
//   count_width  : width of a FIFO occupancy count for a given depth
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Occupancy runs 0..depth inclusive, so one bit more than the address.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (accepted when not full, or when full with a pop)
//   pop        : remove head (ignored when empty)
//   rd_data    : head entry, 0 while empty
//   empty/full : occupancy flags from pointer MSB and equality
//   count      : occupancy, 0..DEPTH
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // is still accepted when it is paired with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Gate the head with empty so stale/uninitialised storage never shows.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with receive FIFO.
//   clk, rst_n      : core clock, asynchronous active-low reset
//   rx              : asynchronous serial input, idle high
//   rd_en           : pop FIFO head
//   rd_data         : FIFO head (valid while empty = 0)
//   empty/full/count: FIFO status
//   busy            : receiver not idle
//   frame_err       : pulse, a stop bit sampled low
//   parity_err      : pulse, parity mismatch
//   overrun         : pulse, good character dropped because FIFO full
//
// Read handshake: rd_data/empty act as a valid/data pair; a read is
// accepted on any cycle with rd_en = 1 and empty = 0, and the next entry
// (if any) appears on rd_data in the following cycle. rd_en while empty
// has no effect.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 8,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rx,
  input  logic                               rd_en,
  output logic [DATA_BITS-1:0]               rd_data,
  output logic                               empty,
  output logic                               full,
  output logic [count_width(FIFO_DEPTH)-1:0] count,
  output logic                               busy,
  output logic                               frame_err,
  output logic                               parity_err,
  output logic                               overrun
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == PAR_ODD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_d;

  rx_state_t              state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [BW-1:0]          bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   par_bad, par_bad_n;
  logic                   stop_idx, stop_idx_n;
  logic                   push_q, push_n;
  logic                   ferr_n, perr_n;
  logic                   sample;

  // Synchroniser resets to the idle level so reset never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_d  <= rxs;
    end
  end

  assign rxs    = sync_q[SYNC_STAGES-1];
  assign sample = (cnt == '0);
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      stop_idx   <= 1'b0;
      push_q     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      par_bad    <= par_bad_n;
      stop_idx   <= stop_idx_n;
      push_q     <= push_n;
      frame_err  <= ferr_n;
      parity_err <= perr_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = sample ? cnt : cnt - 1'b1;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    par_bad_n  = par_bad;
    stop_idx_n = stop_idx;
    push_n     = 1'b0;
    ferr_n     = 1'b0;
    perr_n     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rxs_d && !rxs) begin
          state_n = ST_START;
          cnt_n   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (sample) begin
          if (rxs) begin
            state_n = ST_IDLE;
          end else begin
            state_n   = ST_DATA;
            cnt_n     = BIT_LOAD;
            bit_idx_n = '0;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shreg_n = {rxs, shreg[DATA_BITS-1:1]};
          cnt_n   = BIT_LOAD;
          if (bit_idx == LAST_BIT) begin
            state_n    = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            par_bad_n  = 1'b0;
            stop_idx_n = 1'b0;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          // Even: line bit must equal XOR of data; odd: its inverse.
          par_bad_n = rxs ^ (^shreg) ^ ODD_PAR;
          cnt_n     = BIT_LOAD;
          state_n   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          cnt_n = BIT_LOAD;
          if (!rxs) begin
            ferr_n  = 1'b1;
            state_n = ST_BREAK;
          end else if (stop_idx == LAST_STOP) begin
            perr_n  = par_bad;
            push_n  = ~par_bad;
            state_n = ST_IDLE;
          end else begin
            stop_idx_n = stop_idx + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // Hold here while the line stays low so a break is one error.
        if (rxs) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign overrun = push_q & full & ~rd_en;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (shreg),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int CPB   = 8;
  localparam int DB    = 8;
  localparam int PAR   = 1;
  localparam int SB    = 1;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  // Line slots after the start bit: data, parity, stop.
  localparam int NB    = DB + 1 + SB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          rd_en;
  logic [DB-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [2:0]    count;
  logic          busy;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;

  uart_rx_fifo #(
    .CLK_PER_BIT (CPB),
    .DATA_BITS   (DB),
    .PARITY      (PAR),
    .STOP_BITS   (SB),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / model ----------------
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] exp_push[int];   // posedge index -> character entering FIFO
  bit            exp_ferr[int];   // cycle index -> frame_err high
  bit            exp_perr[int];   // cycle index -> parity_err high
  bit            exp_busy[int];   // cycle index -> busy high
  int            n_ferr = 0;
  int            n_perr = 0;
  int            n_ovr  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Queue model: at each edge pop if reading a non-empty FIFO, then a
  // scheduled character enters if there is room.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_push.exists(cyc) && exp_q.size() < DEPTH) exp_q.push_back(exp_push[cyc]);
    end
  end

  // Compare mid-cycle: outputs for cycle cyc (between posedge cyc and cyc+1).
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_errs", {frame_err, parity_err, overrun}, 0);
    end else begin
      chk("empty", empty, exp_q.size() == 0);
      chk("full", full, exp_q.size() == DEPTH);
      chk("count", count, exp_q.size());
      chk("rd_data", rd_data, (exp_q.size() > 0) ? exp_q[0] : '0);
      chk("busy", busy, exp_busy.exists(cyc));
      chk("frame_err", frame_err, exp_ferr.exists(cyc));
      chk("parity_err", parity_err, exp_perr.exists(cyc));
      chk("overrun", overrun, exp_push.exists(cyc + 1) && exp_q.size() == DEPTH && !rd_en);
      if (frame_err)  n_ferr++;
      if (parity_err) n_perr++;
      if (overrun)    n_ovr++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    wait_cyc(n);
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    wait_cyc(n);
  endtask

  task automatic mark_busy(input int a, input int b);
    for (int i = a; i <= b; i++) exp_busy[i] = 1'b1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) wait_cyc(1);
  endtask

  task automatic rd_pulse();
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
  endtask

  // One frame. f is the first edge at which the start bit is on the line;
  // each later decision lands mid-bit, SYNC cycles behind the line, and
  // the character reaches the FIFO one edge after the stop-bit decision.
  task automatic send_frame(input logic [DB-1:0] d, input bit bad_par,
                            input bit bad_stop, input int hold);
    int   f;
    int   fin;
    logic p;
    f   = cyc + 1;
    fin = f + SYNC + CPB / 2 + CPB * NB;
    p   = (^d) ^ bad_par;
    if (bad_stop) begin
      exp_ferr[fin] = 1'b1;
      mark_busy(f + SYNC, f + CPB * (1 + NB) + hold + 1);
    end else begin
      mark_busy(f + SYNC, fin - 1);
      if (bad_par) exp_perr[fin] = 1'b1;
      else         exp_push[fin + 1] = d;
    end
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DB; i++) drive_bit(d[i], CPB);
    drive_bit(p, CPB);
    drive_bit(~bad_stop, CPB);
    if (bad_stop && hold > 0) drive_bit(1'b0, hold);
    rx = 1'b1;
  endtask

  task automatic glitch(input int g);
    int f;
    f = cyc + 1;
    mark_busy(f + SYNC, f + SYNC + CPB / 2 - 1);
    drive_bit(1'b0, g);
    idle(10);
  endtask

  // ---------------- stimulus ----------------
  int  e0;
  int  f5;
  int  guard;
  bit  done;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(5);

    // Two clean characters, then drain.
    send_frame(8'h55, 0, 0, 0);
    idle(3);
    send_frame(8'hA3, 0, 0, 0);
    idle(3);
    chk("t1_count", count, 2);
    chk("t1_head0", rd_data, 8'h55);
    rd_pulse();
    chk("t1_head1", rd_data, 8'hA3);
    rd_pulse();
    chk("t1_empty", empty, 1);
    chk("t1_no_errs", n_ferr + n_perr + n_ovr, 0);

    // Short low glitch is a false start.
    glitch(3);
    chk("t2_idle", busy, 0);
    chk("t2_count", count, 0);
    chk("t2_no_errs", n_ferr + n_perr + n_ovr, 0);

    // Wrong then right parity.
    e0 = n_perr;
    send_frame(8'h07, 1, 0, 0);
    idle(3);
    chk("t3_perr_once", n_perr - e0, 1);
    chk("t3_empty", empty, 1);
    send_frame(8'h07, 0, 0, 0);
    idle(3);
    chk("t3_head", rd_data, 8'h07);
    rd_pulse();

    // Low stop bit followed by a held-low line.
    e0 = n_ferr;
    send_frame(8'h3C, 0, 1, 40);
    idle(4);
    chk("t4_ferr_once", n_ferr - e0, 1);
    chk("t4_empty", empty, 1);
    send_frame(8'h11, 0, 0, 0);
    idle(3);
    chk("t4_head", rd_data, 8'h11);
    rd_pulse();

    // Overfill, then push into a full FIFO with a simultaneous read.
    e0 = n_ovr;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 0, 0, 0);
      idle(3);
      if (i == 4) chk("t5_full", full, 1);
    end
    chk("t5_ovr_once", n_ovr - e0, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("t5_order", rd_data, i);
      rd_pulse();
    end
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h10 + 8'(i), 0, 0, 0);
      idle(3);
    end
    e0 = n_ovr;
    f5 = cyc + 1;
    fork
      send_frame(8'h14, 0, 0, 0);
      begin
        wait_until(f5 + SYNC + CPB / 2 + CPB * NB);
        rd_pulse();
      end
    join
    idle(3);
    chk("t5_count_kept", count, 4);
    chk("t5_no_ovr", n_ovr - e0, 0);
    chk("t5_head_after", rd_data, 8'h11);
    for (int i = 0; i < 4; i++) rd_pulse();

    // Reset in the middle of the data bits of 0x9E.
    begin
      logic [7:0] d;
      int         f;
      d = 8'h9E;
      f = cyc + 1;
      mark_busy(f + SYNC, f - 1 + 5 * CPB - 1);
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive_bit(d[i], CPB);
      rst_n = 1'b0;
      rx    = 1'b1;
      wait_cyc(3);
      chk("t6_rst_count", count, 0);
      chk("t6_rst_busy", busy, 0);
      rst_n = 1'b1;
      idle(4);
      send_frame(8'h42, 0, 0, 0);
      idle(3);
      chk("t6_count", count, 1);
      chk("t6_head", rd_data, 8'h42);
      rd_pulse();
    end

    // Randomised traffic with a random reader.
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          int          r;
          logic [7:0]  d;
          r = $urandom_range(0, 9);
          d = 8'($urandom_range(0, 255));
          if (r == 0)      glitch($urandom_range(1, 3));
          else if (r == 1) send_frame(d, 1, 0, 0);
          else if (r == 2) send_frame(d, 0, 1, $urandom_range(0, 20));
          else             send_frame(d, 0, 0, 0);
          idle($urandom_range(2, 12));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rd_en = ($urandom_range(0, 3) == 0);
          wait_cyc(1);
        end
        rd_en = 1'b0;
      end
    join
    idle(20);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      rd_pulse();
      guard++;
    end
    idle(2);
    chk("end_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
